dmem_responder: RTL and testbench

Data-memory responder for the five-stage pipeline. It receives load/store requests from the EX/MEM side of the memory stage and serves them from a synchronous-read data RAM or a valid/ready MMIO port. It performs RISC-V byte-lane steering, sign/zero extension and misalignment detection, and returns formatted load data for capture into the MEM/WB register. It holds the pipeline with `stall` while an access is outstanding.

---
 rtl/dmem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: serves loads/stores from a synchronous-read RAM
// or a valid/ready MMIO port, with RISC-V byte-lane steering, load extension and misalignment drop.
module dmem_responder #(
   parameter int          ADDR_W  = 14,
   parameter logic [15:0] MMIO_HI = 16'hC000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              rdata_valid,
   output logic              misaligned,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic              mmio_valid,
   output logic              mmio_we,
   output logic [3:0]        mmio_be,
   output logic [31:0]       mmio_addr,
   output logic [31:0]       mmio_wdata,
   input  logic              mmio_ready,
   input  logic [31:0]       mmio_rdata
);

   // state     | meaning
   // IDLE      | accepting requests; stores and misaligned drops finish here
   // RAM_RD    | RAM read data arriving; format and return it
   // MMIO_WAIT | MMIO request outstanding, waiting for mmio_ready
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAM_RD    = 2'd1,
      MMIO_WAIT = 2'd2
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   state_t      state, state_nxt;
   logic [1:0]  lat_a;
   logic [2:0]  lat_f3;
   logic [2:0]  eff_f3;
   logic [1:0]  a;
   logic        is_mis;
   logic        mmio_hit;
   logic        start_mmio;
   logic [3:0]  lanes;
   logic [31:0] steered;

   // Anything not a legal size for the access direction collapses to a word access.
   function automatic logic [2:0] norm_f3(input logic we, input logic [2:0] f3);
      logic [2:0] r;
      case (f3)
         F3_B, F3_H, F3_W: r = f3;
         F3_BU, F3_HU:     r = we ? F3_W : f3;
         default:          r = F3_W;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] ofs);
      logic [3:0] r;
      case (f3)
         F3_B, F3_BU: r = 4'b0001 << ofs;
         F3_H, F3_HU: r = ofs[1] ? 4'b1100 : 4'b0011;
         default:     r = 4'b1111;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] steer(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      case (f3)
         F3_B:    r = {4{wd[7:0]}};
         F3_H:    r = {2{wd[15:0]}};
         default: r = wd;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] ofs,
                                            input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[{ofs, 3'b000} +: 8];
      h = ofs[1] ? w[31:16] : w[15:0];
      case (f3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_BU:   r = {24'h0, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_HU:   r = {16'h0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   always_comb begin
      a        = req_addr[1:0];
      eff_f3   = norm_f3(req_we, req_funct3);
      lanes    = lane_mask(eff_f3, a);
      steered  = steer(eff_f3, req_wdata);
      mmio_hit = (req_addr[31:16] == MMIO_HI);
      case (eff_f3)
         F3_H, F3_HU: is_mis = a[0];
         F3_W:        is_mis = (a != 2'b00);
         default:     is_mis = 1'b0;
      endcase
   end

   // Outputs are gated by rst so a held request cannot re-raise stall while reset is active.
   always_comb begin
      state_nxt   = state;
      stall       = 1'b0;
      rdata       = 32'h0;
      rdata_valid = 1'b0;
      misaligned  = 1'b0;
      ram_en      = 1'b0;
      ram_we      = 4'b0000;
      ram_addr    = '0;
      ram_wdata   = 32'h0;
      start_mmio  = 1'b0;
      if (rst) begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (is_mis) begin
                     misaligned = 1'b1;
                  end else if (mmio_hit) begin
                     stall      = 1'b1;
                     start_mmio = 1'b1;
                     state_nxt  = MMIO_WAIT;
                  end else begin
                     ram_en   = 1'b1;
                     ram_addr = req_addr[ADDR_W+1:2];
                     if (req_we) begin
                        ram_we    = lanes;
                        ram_wdata = steered;
                     end else begin
                        stall     = 1'b1;
                        state_nxt = RAM_RD;
                     end
                  end
               end
            end
            RAM_RD: begin
               rdata_valid = 1'b1;
               rdata       = fmt_load(ram_rdata, lat_a, lat_f3);
               state_nxt   = IDLE;
            end
            MMIO_WAIT: begin
               if (mmio_ready) begin
                  rdata_valid = ~mmio_we;
                  if (!mmio_we) rdata = fmt_load(mmio_rdata, lat_a, lat_f3);
                  state_nxt = IDLE;
               end else begin
                  stall = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         lat_a      <= 2'b00;
         lat_f3     <= 3'b000;
         mmio_valid <= 1'b0;
         mmio_we    <= 1'b0;
         mmio_be    <= 4'b0000;
         mmio_addr  <= 32'h0;
         mmio_wdata <= 32'h0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            lat_a  <= a;
            lat_f3 <= eff_f3;
         end
         if (start_mmio) begin
            mmio_valid <= 1'b1;
            mmio_we    <= req_we;
            mmio_be    <= lanes;
            mmio_addr  <= req_addr;
            mmio_wdata <= steered;
         end else if (state == MMIO_WAIT && mmio_ready) begin
            mmio_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of RAM accesses plus hand-written MMIO,
// reset-abort and back-to-back sequences against a behavioural RAM model.
module tb_dmem_responder;

   localparam int ADDR_W = 14;
   localparam int NV     = 21;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr, req_wdata;
   logic              stall, rdata_valid, misaligned;
   logic [31:0]       rdata;
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata, ram_rdata;
   logic              mmio_valid, mmio_we, mmio_ready;
   logic [3:0]        mmio_be;
   logic [31:0]       mmio_addr, mmio_wdata, mmio_rdata;

   int checks = 0;
   int failures = 0;
   int rd_cnt = 0;
   int rd_base;

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(ADDR_W), .MMIO_HI(16'hC000)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .misaligned(misaligned),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .mmio_valid(mmio_valid), .mmio_we(mmio_we), .mmio_be(mmio_be),
      .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
      .mmio_ready(mmio_ready), .mmio_rdata(mmio_rdata)
   );

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we == 4'b0000) begin
            ram_rdata <= mem[ram_addr];
            rd_cnt    <= rd_cnt + 1;
         end else begin
            for (int b = 0; b < 4; b++)
               if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] ad, input logic [31:0] wd);
      req_valid  = v;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = ad;
      req_wdata  = wd;
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] ewd;
      logic        mis;
      logic [31:0] erd;
   } vec_t;

   vec_t vt [NV];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'h0;
      ram_rdata  = 32'h0;
      mmio_ready = 1'b0;
      mmio_rdata = 32'h0;
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

      vt[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
      vt[1]  = '{1'b0, 3'b010, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF};
      vt[2]  = '{1'b1, 3'b000, 32'h13, 32'h00000080, 4'h8, 32'h80808080, 1'b0, 32'h0};
      vt[3]  = '{1'b0, 3'b000, 32'h13, 32'h0, 4'h0, 32'h0, 1'b0, 32'hFFFFFF80};
      vt[4]  = '{1'b0, 3'b100, 32'h13, 32'h0, 4'h0, 32'h0, 1'b0, 32'h00000080};
      vt[5]  = '{1'b1, 3'b010, 32'h20, 32'h80017FFF, 4'hF, 32'h80017FFF, 1'b0, 32'h0};
      vt[6]  = '{1'b0, 3'b001, 32'h22, 32'h0, 4'h0, 32'h0, 1'b0, 32'hFFFF8001};
      vt[7]  = '{1'b0, 3'b101, 32'h22, 32'h0, 4'h0, 32'h0, 1'b0, 32'h00008001};
      vt[8]  = '{1'b0, 3'b001, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0, 32'h00007FFF};
      vt[9]  = '{1'b0, 3'b001, 32'h21, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0};
      vt[10] = '{1'b1, 3'b001, 32'h1E, 32'hAAAA1234, 4'hC, 32'h12341234, 1'b0, 32'h0};
      vt[11] = '{1'b0, 3'b010, 32'h1C, 32'h0, 4'h0, 32'h0, 1'b0, 32'h12340000};
      vt[12] = '{1'b0, 3'b010, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0};
      vt[13] = '{1'b1, 3'b100, 32'h30, 32'h11223344, 4'hF, 32'h11223344, 1'b0, 32'h0};
      vt[14] = '{1'b0, 3'b000, 32'h31, 32'h0, 4'h0, 32'h0, 1'b0, 32'h00000033};
      vt[15] = '{1'b0, 3'b011, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, 32'h11223344};
      vt[16] = '{1'b0, 3'b101, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0000BEEF};
      vt[17] = '{1'b0, 3'b000, 32'h11, 32'h0, 4'h0, 32'h0, 1'b0, 32'hFFFFFFBE};
      vt[18] = '{1'b1, 3'b010, 32'h33, 32'h00000055, 4'h0, 32'h0, 1'b1, 32'h0};
      vt[19] = '{1'b0, 3'b101, 32'h32, 32'h0, 4'h0, 32'h0, 1'b0, 32'h00001122};
      vt[20] = '{1'b0, 3'b010, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, 32'h11223344};

      // reset values
      rst = 1'b0;
      #12;
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_rdata_valid", 32'(rdata_valid), 32'h0);
      check("rst_misaligned", 32'(misaligned), 32'h0);
      check("rst_ram_en", 32'(ram_en), 32'h0);
      check("rst_ram_we", 32'(ram_we), 32'h0);
      check("rst_ram_addr", 32'(ram_addr), 32'h0);
      check("rst_ram_wdata", ram_wdata, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_mmio_valid", 32'(mmio_valid), 32'h0);
      check("rst_mmio_we", 32'(mmio_we), 32'h0);
      check("rst_mmio_be", 32'(mmio_be), 32'h0);
      check("rst_mmio_addr", mmio_addr, 32'h0);
      check("rst_mmio_wdata", mmio_wdata, 32'h0);
      @(posedge clk); #1 rst = 1'b1;

      // table-driven RAM accesses
      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         drive(1'b1, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd);
         @(negedge clk);
         check($sformatf("v%0d_misaligned", i), 32'(misaligned), 32'(vt[i].mis));
         check($sformatf("v%0d_ram_en", i), 32'(ram_en), 32'(!vt[i].mis));
         check($sformatf("v%0d_stall", i), 32'(stall), 32'(!vt[i].we && !vt[i].mis));
         if (!vt[i].mis) begin
            check($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vt[i].addr[ADDR_W+1:2]));
            check($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vt[i].we ? vt[i].be : 4'h0));
            if (vt[i].we) check($sformatf("v%0d_ram_wdata", i), ram_wdata, vt[i].ewd);
         end
         if (!vt[i].we && !vt[i].mis) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_rdata_valid", i), 32'(rdata_valid), 32'h1);
            check($sformatf("v%0d_rdata", i), rdata, vt[i].erd);
            check($sformatf("v%0d_rd_stall", i), 32'(stall), 32'h0);
            check($sformatf("v%0d_rd_ram_en", i), 32'(ram_en), 32'h0);
         end else begin
            check($sformatf("v%0d_no_rvalid", i), 32'(rdata_valid), 32'h0);
         end
      end
      @(posedge clk); #1 drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

      // MMIO word load, ready on the 4th cycle of mmio_valid
      @(posedge clk); #1 drive(1'b1, 1'b0, 3'b010, 32'hC0000004, 32'h0);
      @(negedge clk);
      check("mmio_c0_stall", 32'(stall), 32'h1);
      check("mmio_c0_ram_en", 32'(ram_en), 32'h0);
      check("mmio_c0_valid", 32'(mmio_valid), 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("mmio_w%0d_valid", k), 32'(mmio_valid), 32'h1);
         check($sformatf("mmio_w%0d_addr", k), mmio_addr, 32'hC0000004);
         check($sformatf("mmio_w%0d_be", k), 32'(mmio_be), 32'hF);
         check($sformatf("mmio_w%0d_we", k), 32'(mmio_we), 32'h0);
         check($sformatf("mmio_w%0d_stall", k), 32'(stall), 32'h1);
      end
      @(posedge clk); #1 begin mmio_ready = 1'b1; mmio_rdata = 32'hCAFEF00D; end
      @(negedge clk);
      check("mmio_rdy_stall", 32'(stall), 32'h0);
      check("mmio_rdy_rvalid", 32'(rdata_valid), 32'h1);
      check("mmio_rdy_rdata", rdata, 32'hCAFEF00D);
      check("mmio_rdy_valid", 32'(mmio_valid), 32'h1);
      @(posedge clk); #1 begin mmio_ready = 1'b0; drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); end
      @(negedge clk);
      check("mmio_done_valid", 32'(mmio_valid), 32'h0);
      check("mmio_done_stall", 32'(stall), 32'h0);

      // MMIO byte store, ready on first waiting cycle
      @(posedge clk); #1 drive(1'b1, 1'b1, 3'b000, 32'hC0000013, 32'h0000005A);
      @(negedge clk);
      check("mmsb_c0_stall", 32'(stall), 32'h1);
      @(posedge clk); #1 mmio_ready = 1'b1;
      @(negedge clk);
      check("mmsb_valid", 32'(mmio_valid), 32'h1);
      check("mmsb_we", 32'(mmio_we), 32'h1);
      check("mmsb_be", 32'(mmio_be), 32'h8);
      check("mmsb_wdata", mmio_wdata, 32'h5A5A5A5A);
      check("mmsb_stall", 32'(stall), 32'h0);
      check("mmsb_rvalid", 32'(rdata_valid), 32'h0);
      @(posedge clk); #1 begin mmio_ready = 1'b0; drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); end

      // reset while waiting on MMIO; request stays held through the reset
      @(posedge clk); #1 drive(1'b1, 1'b0, 3'b010, 32'hC0000008, 32'h0);
      @(posedge clk); @(negedge clk);
      check("rstw_valid_before", 32'(mmio_valid), 32'h1);
      #2 rst = 1'b0;
      #1;
      check("rstw_valid_async", 32'(mmio_valid), 32'h0);
      check("rstw_stall_async", 32'(stall), 32'h0);
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("rstw_valid_after", 32'(mmio_valid), 32'h0);
      @(posedge clk); #1 drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      @(negedge clk);
      check("rstw_ld_stall", 32'(stall), 32'h1);
      @(posedge clk); @(negedge clk);
      check("rstw_ld_rvalid", 32'(rdata_valid), 32'h1);
      check("rstw_ld_rdata", rdata, 32'h80ADBEEF);
      @(posedge clk); #1 drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

      // back-to-back SW/SW/LW/LW/SW with no idle cycles
      @(posedge clk); #1 drive(1'b1, 1'b1, 3'b010, 32'h0, 32'hA1A1A1A1);
      rd_base = rd_cnt;
      @(negedge clk);
      check("b2b_sw0_stall", 32'(stall), 32'h0);
      @(posedge clk); #1 drive(1'b1, 1'b1, 3'b010, 32'h4, 32'hB2B2B2B2);
      @(posedge clk); #1 drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
      @(negedge clk);
      check("b2b_lw0_stall", 32'(stall), 32'h1);
      @(posedge clk); @(negedge clk);
      check("b2b_lw0_rdata", rdata, 32'hA1A1A1A1);
      check("b2b_lw0_rvalid", 32'(rdata_valid), 32'h1);
      @(posedge clk); #1 drive(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
      @(negedge clk);
      check("b2b_lw4_stall", 32'(stall), 32'h1);
      @(posedge clk); @(negedge clk);
      check("b2b_lw4_rdata", rdata, 32'hB2B2B2B2);
      @(posedge clk); #1 drive(1'b1, 1'b1, 3'b010, 32'h8, 32'hC3C3C3C3);
      @(negedge clk);
      check("b2b_sw8_stall", 32'(stall), 32'h0);
      check("b2b_sw8_ram_we", 32'(ram_we), 32'hF);
      @(posedge clk); #1 drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      check("b2b_read_count", 32'(rd_cnt - rd_base), 32'h2);
      check("b2b_mem8", mem[2], 32'hC3C3C3C3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
